// File: rtl/biu_prefetch_queue_pkg.sv
// Shared types and helpers for the BIU prefetch queue: bus-cycle states and
// segment:offset to physical address translation.
package biu_pkg;

  localparam int SEG_SHIFT = 4;

  typedef enum logic [2:0] {IDLE, T1, T2, T3, TW, T4} biu_state_t;

  // Full 21-bit sum; the caller reduces it modulo 2^ADDR_W.
  function automatic logic [20:0] phys_addr(input logic [15:0] seg, input logic [15:0] off);
    return ({5'b0, seg} << SEG_SHIFT) + {5'b0, off};
  endfunction

endpackage

// File: rtl/biu_prefetch_queue_if.sv
// External bus of the prefetch unit: address/strobes out, READY and read data in.
interface biu_prefetch_queue_if #(
  parameter int BUS_BYTES = 1,
  parameter int ADDR_W    = 20
);
  logic [ADDR_W-1:0]      addr;
  logic                   ale;
  logic                   rd_n;
  logic                   ready;
  logic [8*BUS_BYTES-1:0] bus_data;

  modport master (output addr, output ale, output rd_n, input ready, input bus_data);
  modport slave  (input addr, input ale, input rd_n, output ready, output bus_data);
endinterface

// File: rtl/biu_prefetch_queue_fifo.sv
// Byte FIFO with a multi-byte push (0..MAX_PUSH bytes per edge), single pop
// and synchronous clear. Storage is not reset; only pointers and count are.
module byte_fifo #(
  parameter int DEPTH    = 6,
  parameter int MAX_PUSH = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i_clear,
  input  logic [$clog2(MAX_PUSH+1)-1:0] i_push_n,
  input  logic [8*MAX_PUSH-1:0]        i_push_data,
  input  logic                         i_pop,
  output logic [7:0]                   o_head,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [7:0]       r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd;
  logic [PTR_W-1:0] r_wr;
  logic [CNT_W-1:0] r_cnt;
  logic             w_do_pop;

  // Pointers wrap modulo DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= DEPTH) s = s - DEPTH;
    return PTR_W'(s);
  endfunction

  assign w_do_pop = i_pop && (r_cnt != '0);

  always_ff @(posedge clk) begin
    if (!reset || i_clear) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_do_pop) r_rd <= ptr_add(r_rd, 1);
      r_wr  <= ptr_add(r_wr, int'(i_push_n));
      r_cnt <= r_cnt + CNT_W'(i_push_n) - CNT_W'(w_do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!i_clear) begin
      for (int i = 0; i < MAX_PUSH; i++) begin
        if (i < int'(i_push_n)) r_mem[ptr_add(r_wr, i)] <= i_push_data[8*i +: 8];
      end
    end
  end

  assign o_head  = r_mem[r_rd];
  assign o_count = r_cnt;

endmodule

// File: rtl/biu_prefetch_queue.sv
// Autonomous code prefetcher: runs T1-T4 bus cycles (with READY wait states)
// at CS:IP and stuffs the fetched bytes into a byte FIFO read by the EU.
module biu_prefetch_queue
  import biu_pkg::*;
#(
  parameter int DEPTH     = 6,
  parameter int BUS_BYTES = 1,
  parameter int ADDR_W    = 20
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [15:0]                cs,
  input  logic                       ip_load_en,
  input  logic [15:0]                ip_load_val,
  input  logic                       fetch_en,
  biu_prefetch_queue_if.master       bus,
  input  logic                       q_pop,
  output logic [7:0]                 q_byte,
  output logic                       q_valid,
  output logic [$clog2(DEPTH+1)-1:0] q_count,
  output logic [15:0]                fetch_ip,
  output logic                       bus_busy
);
  localparam int PN_W  = $clog2(BUS_BYTES+1);
  localparam int CNT_W = $clog2(DEPTH+1);

  biu_state_t             r_state;
  logic [15:0]            r_fetch_ip;
  logic                   r_abort;
  logic [ADDR_W-1:0]      r_addr;
  logic                   r_ale;
  logic                   r_rd_n;
  logic [8*BUS_BYTES-1:0] r_cap;

  logic [PN_W-1:0]        w_push_n;
  logic [15:0]            w_ip_after;
  logic                   w_start;
  logic                   w_capture;
  logic [8*BUS_BYTES-1:0] w_lane;
  logic [CNT_W-1:0]       w_count;

  // An odd address on a 16-bit bus only yields its high byte.
  function automatic int fetch_len(input logic [15:0] ip);
    return (BUS_BYTES == 2 && ip[0]) ? 1 : BUS_BYTES;
  endfunction

  // Start check uses the post-push count so back-to-back fetches never overfill.
  always_comb begin
    w_push_n   = '0;
    w_ip_after = r_fetch_ip;
    if (r_state == T4 && !r_abort) begin
      w_ip_after = r_fetch_ip + 16'(fetch_len(r_fetch_ip));
      if (!ip_load_en) w_push_n = PN_W'(fetch_len(r_fetch_ip));
    end
    w_start   = fetch_en && !ip_load_en &&
                ((DEPTH - int'(w_count) - int'(w_push_n)) >= fetch_len(w_ip_after));
    w_capture = (r_state == T3 || r_state == TW) && bus.ready;
    w_lane    = (BUS_BYTES == 2 && r_fetch_ip[0]) ? (bus.bus_data >> 8) : bus.bus_data;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_fetch_ip <= '0;
      r_abort    <= 1'b0;
      r_addr     <= '0;
      r_ale      <= 1'b0;
      r_rd_n     <= 1'b1;
    end else begin
      r_fetch_ip <= ip_load_en ? ip_load_val : w_ip_after;
      if (ip_load_en && r_state inside {T1, T2, T3, TW}) r_abort <= 1'b1;
      else if (r_state == T4)                             r_abort <= 1'b0;
      unique case (r_state)
        IDLE, T4: begin
          if (w_start) begin
            r_state <= T1;
            r_ale   <= 1'b1;
            r_addr  <= ADDR_W'(phys_addr(cs, w_ip_after));
          end else begin
            r_state <= IDLE;
          end
        end
        T1: begin
          r_state <= T2;
          r_ale   <= 1'b0;
          r_rd_n  <= 1'b0;
        end
        T2: r_state <= T3;
        T3, TW: begin
          if (bus.ready) begin
            r_state <= T4;
            r_rd_n  <= 1'b1;
          end else begin
            r_state <= TW;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_capture) r_cap <= w_lane;
  end

  byte_fifo #(.DEPTH(DEPTH), .MAX_PUSH(BUS_BYTES)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_clear     (ip_load_en),
    .i_push_n    (w_push_n),
    .i_push_data (r_cap),
    .i_pop       (q_pop),
    .o_head      (q_byte),
    .o_count     (w_count)
  );

  assign bus.addr = r_addr;
  assign bus.ale  = r_ale;
  assign bus.rd_n = r_rd_n;
  assign q_count  = w_count;
  assign q_valid  = (w_count != '0);
  assign fetch_ip = r_fetch_ip;
  assign bus_busy = (r_state != IDLE);

endmodule

// File: tb/tb_biu_prefetch_queue.sv
// Directed bench: instance A is 8-bit bus / 4-deep, instance B is 16-bit bus / 6-deep.
module tb_biu_prefetch_queue;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [15:0] a_cs, a_ip_val, a_fip;
  logic        a_ip_load, a_fetch_en, a_pop, a_qvalid, a_busy;
  logic [7:0]  a_qbyte;
  logic [2:0]  a_qcount;
  logic [7:0]  a_rom [4];
  biu_prefetch_queue_if #(.BUS_BYTES(1), .ADDR_W(20)) a_bus();
  always_comb a_bus.bus_data = a_rom[a_bus.addr[1:0]];

  biu_prefetch_queue #(.DEPTH(4), .BUS_BYTES(1), .ADDR_W(20)) dut_a (
    .clk(clk), .reset(reset), .cs(a_cs), .ip_load_en(a_ip_load), .ip_load_val(a_ip_val),
    .fetch_en(a_fetch_en), .bus(a_bus), .q_pop(a_pop), .q_byte(a_qbyte), .q_valid(a_qvalid),
    .q_count(a_qcount), .fetch_ip(a_fip), .bus_busy(a_busy));

  logic [15:0] b_cs, b_ip_val, b_fip;
  logic        b_ip_load, b_fetch_en, b_pop, b_qvalid, b_busy;
  logic [7:0]  b_qbyte;
  logic [2:0]  b_qcount;
  biu_prefetch_queue_if #(.BUS_BYTES(2), .ADDR_W(20)) b_bus();

  biu_prefetch_queue #(.DEPTH(6), .BUS_BYTES(2), .ADDR_W(20)) dut_b (
    .clk(clk), .reset(reset), .cs(b_cs), .ip_load_en(b_ip_load), .ip_load_val(b_ip_val),
    .fetch_en(b_fetch_en), .bus(b_bus), .q_pop(b_pop), .q_byte(b_qbyte), .q_valid(b_qvalid),
    .q_count(b_qcount), .fetch_ip(b_fip), .bus_busy(b_busy));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_flush(input logic [15:0] ip);
    a_ip_val = ip; a_ip_load = 1'b1;
    tick();
    a_ip_load = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick(); tick();
    checks++; if (a_bus.rd_n !== 1'b1) begin errors++; $display("FAIL reset_rd_n: got %b want 1", a_bus.rd_n); end
    checks++; if (a_bus.ale !== 1'b0) begin errors++; $display("FAIL reset_ale: got %b want 0", a_bus.ale); end
    checks++; if (a_bus.addr !== 20'h0) begin errors++; $display("FAIL reset_addr: got %h want 00000", a_bus.addr); end
    checks++; if (a_qcount !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", a_qcount); end
    checks++; if (a_qvalid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", a_qvalid); end
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", a_busy); end
    checks++; if (b_bus.rd_n !== 1'b1 || b_busy !== 1'b0 || b_qcount !== 3'd0)
      begin errors++; $display("FAIL reset_b: got rd_n=%b busy=%b count=%0d want 1 0 0", b_bus.rd_n, b_busy, b_qcount); end
    reset = 1'b1;
  endtask

  task automatic test_basic_fill();
    logic [7:0] exp [4];
    exp = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    a_rom = exp;
    a_cs = 16'h1000;
    a_flush(16'h0010);
    checks++; if (a_fip !== 16'h0010) begin errors++; $display("FAIL fill_load_ip: got %h want 0010", a_fip); end
    a_fetch_en = 1'b1; a_bus.ready = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (a_bus.ale !== 1'b1 || a_bus.addr !== 20'h10010 + 20'(k))
        begin errors++; $display("FAIL fill_addr%0d: got ale=%b addr=%h want 1 %h", k, a_bus.ale, a_bus.addr, 20'h10010 + 20'(k)); end
      tick(); tick(); tick(); tick();
      checks++; if (a_qcount !== 3'(k + 1)) begin errors++; $display("FAIL fill_count%0d: got %0d want %0d", k, a_qcount, k + 1); end
    end
    tick(); tick();
    checks++; if (a_busy !== 1'b0 || a_qcount !== 3'd4)
      begin errors++; $display("FAIL fill_idle: got busy=%b count=%0d want 0 4", a_busy, a_qcount); end
    a_fetch_en = 1'b0; a_pop = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks++; if (a_qbyte !== exp[k]) begin errors++; $display("FAIL fill_pop%0d: got %h want %h", k, a_qbyte, exp[k]); end
      tick();
    end
    checks++; if (a_qcount !== 3'd0 || a_qvalid !== 1'b0)
      begin errors++; $display("FAIL fill_empty: got count=%0d valid=%b want 0 0", a_qcount, a_qvalid); end
    tick();
    checks++; if (a_qcount !== 3'd0) begin errors++; $display("FAIL pop_underflow: got %0d want 0", a_qcount); end
    a_pop = 1'b0;
  endtask

  task automatic test_wait_states();
    a_rom = '{8'h5A, 8'h6B, 8'h7C, 8'h8D};
    a_flush(16'h0020);
    a_fetch_en = 1'b1; a_bus.ready = 1'b0;
    tick(); tick();
    checks++; if (a_bus.rd_n !== 1'b0) begin errors++; $display("FAIL ws_t2_rd_n: got %b want 0", a_bus.rd_n); end
    tick();
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (a_bus.rd_n !== 1'b0 || a_qcount !== 3'd0)
        begin errors++; $display("FAIL ws_tw%0d: got rd_n=%b count=%0d want 0 0", k, a_bus.rd_n, a_qcount); end
    end
    a_bus.ready = 1'b1;
    tick();
    checks++; if (a_bus.rd_n !== 1'b1 || a_qcount !== 3'd0)
      begin errors++; $display("FAIL ws_t4: got rd_n=%b count=%0d want 1 0", a_bus.rd_n, a_qcount); end
    a_fetch_en = 1'b0;
    tick();
    checks++; if (a_qcount !== 3'd1 || a_qbyte !== 8'h5A || a_busy !== 1'b0)
      begin errors++; $display("FAIL ws_push: got count=%0d byte=%h busy=%b want 1 5a 0", a_qcount, a_qbyte, a_busy); end
    a_flush(16'h0000);
  endtask

  task automatic test_flush_mid_fetch();
    a_flush(16'h0100);
    a_fetch_en = 1'b1; a_bus.ready = 1'b1;
    tick();
    checks++; if (a_bus.addr !== 20'h10100) begin errors++; $display("FAIL flush_first_addr: got %h want 10100", a_bus.addr); end
    tick();
    a_flush(16'h0200);
    checks++; if (a_fip !== 16'h0200 || a_qcount !== 3'd0)
      begin errors++; $display("FAIL flush_reload: got ip=%h count=%0d want 0200 0", a_fip, a_qcount); end
    tick(); tick();
    checks++; if (a_qcount !== 3'd0 || a_bus.addr !== 20'h10200 || a_bus.ale !== 1'b1)
      begin errors++; $display("FAIL flush_discard: got count=%0d addr=%h ale=%b want 0 10200 1", a_qcount, a_bus.addr, a_bus.ale); end
    a_fetch_en = 1'b0;
    tick();
    a_flush(16'h0200);
    tick(); tick(); tick();
    checks++; if (a_busy !== 1'b0 || a_qcount !== 3'd0)
      begin errors++; $display("FAIL flush_abort_idle: got busy=%b count=%0d want 0 0", a_busy, a_qcount); end
  endtask

  task automatic test_pop_push();
    logic [7:0] exp [4];
    exp = '{8'h11, 8'h22, 8'h33, 8'h44};
    a_rom = exp;
    a_flush(16'h0030);
    a_fetch_en = 1'b1;
    for (int k = 0; k < 13; k++) tick();
    checks++; if (a_qcount !== 3'd3) begin errors++; $display("FAIL pp_fill3: got %0d want 3", a_qcount); end
    a_fetch_en = 1'b0;
    tick(); tick(); tick();
    a_pop = 1'b1;
    tick();
    checks++; if (a_qcount !== 3'd3 || a_qbyte !== 8'h22 || a_busy !== 1'b0)
      begin errors++; $display("FAIL pp_same_edge: got count=%0d byte=%h busy=%b want 3 22 0", a_qcount, a_qbyte, a_busy); end
    for (int k = 1; k < 4; k++) begin
      checks++; if (a_qbyte !== exp[k]) begin errors++; $display("FAIL pp_order%0d: got %h want %h", k, a_qbyte, exp[k]); end
      tick();
    end
    a_pop = 1'b0;
    checks++; if (a_qcount !== 3'd0) begin errors++; $display("FAIL pp_drain: got %0d want 0", a_qcount); end
  endtask

  task automatic test_addr_wrap();
    a_cs = 16'hFFFF;
    a_flush(16'h0010);
    a_fetch_en = 1'b1;
    tick();
    checks++; if (a_bus.addr !== 20'h00000 || a_bus.ale !== 1'b1)
      begin errors++; $display("FAIL wrap_addr: got addr=%h ale=%b want 00000 1", a_bus.addr, a_bus.ale); end
    a_fetch_en = 1'b0;
    a_flush(16'h0000);
    tick(); tick(); tick(); tick();
    checks++; if (a_busy !== 1'b0 || a_qcount !== 3'd0)
      begin errors++; $display("FAIL wrap_idle: got busy=%b count=%0d want 0 0", a_busy, a_qcount); end
  endtask

  task automatic test_odd_16bit();
    logic [7:0] exp [3];
    exp = '{8'h55, 8'hAA, 8'h55};
    b_cs = 16'h1000; b_bus.bus_data = 16'h55AA; b_bus.ready = 1'b1;
    b_ip_val = 16'h0011; b_ip_load = 1'b1;
    tick();
    b_ip_load = 1'b0; b_fetch_en = 1'b1;
    tick();
    checks++; if (b_bus.addr !== 20'h10011) begin errors++; $display("FAIL odd_addr: got %h want 10011", b_bus.addr); end
    tick(); tick(); tick(); tick();
    checks++; if (b_qcount !== 3'd1 || b_qbyte !== 8'h55 || b_fip !== 16'h0012)
      begin errors++; $display("FAIL odd_push1: got count=%0d byte=%h ip=%h want 1 55 0012", b_qcount, b_qbyte, b_fip); end
    checks++; if (b_bus.addr !== 20'h10012) begin errors++; $display("FAIL odd_next_addr: got %h want 10012", b_bus.addr); end
    b_fetch_en = 1'b0;
    tick(); tick(); tick(); tick();
    checks++; if (b_qcount !== 3'd3 || b_fip !== 16'h0014 || b_busy !== 1'b0)
      begin errors++; $display("FAIL even_push2: got count=%0d ip=%h busy=%b want 3 0014 0", b_qcount, b_fip, b_busy); end
    b_pop = 1'b1;
    for (int k = 0; k < 3; k++) begin
      checks++; if (b_qbyte !== exp[k]) begin errors++; $display("FAIL odd_order%0d: got %h want %h", k, b_qbyte, exp[k]); end
      tick();
    end
    b_pop = 1'b0;
    checks++; if (b_qcount !== 3'd0) begin errors++; $display("FAIL odd_drain: got %0d want 0", b_qcount); end
  endtask

  initial begin
    reset = 1'b0;
    a_cs = 16'h0; a_ip_val = 16'h0; a_ip_load = 1'b0; a_fetch_en = 1'b0; a_pop = 1'b0;
    a_rom = '{8'h00, 8'h00, 8'h00, 8'h00};
    a_bus.ready = 1'b1;
    b_cs = 16'h0; b_ip_val = 16'h0; b_ip_load = 1'b0; b_fetch_en = 1'b0; b_pop = 1'b0;
    b_bus.ready = 1'b1; b_bus.bus_data = 16'h0000;
    test_reset();
    test_basic_fill();
    test_wait_states();
    test_flush_mid_fetch();
    test_pop_push();
    test_addr_wrap();
    test_odd_16bit();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
